// File: rtl/ifft8_seq_if.sv
// Stream bundle for ifft8_seq: frequency bins in, time samples out, plus busy.
// slave = engine side, master = source/sink side.
interface ifft8_seq_if #(parameter int N = 16);
  logic                s_valid;
  logic                s_ready;
  logic signed [N-1:0] s_data_r;
  logic signed [N-1:0] s_data_i;
  logic                m_valid;
  logic                m_ready;
  logic signed [N-1:0] m_data_r;
  logic signed [N-1:0] m_data_i;
  logic                m_last;
  logic                busy;

  modport slave  (input  s_valid, s_data_r, s_data_i, m_ready,
                  output s_ready, m_valid, m_data_r, m_data_i, m_last, busy);
  modport master (output s_valid, s_data_r, s_data_i, m_ready,
                  input  s_ready, m_valid, m_data_r, m_data_i, m_last, busy);
endinterface

// File: rtl/ifft8_seq.sv
// 8-point in-place radix-2 DIF inverse FFT with 1/8 scaling; IFFT8_ROUND_EN selects round+saturate.
// First output 13 cycles after the 8th input beat; no frame overlap, output stalls while m_ready is low.
module ifft8_seq #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input  logic         clk,
  input  logic         rst,
  ifft8_seq_if.slave   bus
);
  localparam int P   = 2 * N + 2;
  localparam int ONE = 1 << Q;
  localparam int C45 = int'(0.7071067811865476 * real'(ONE));

  typedef enum logic [1:0] {ST_LOAD, ST_COMP, ST_OUT} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_in_cnt, r_out_cnt;
  logic [1:0]          r_stage, r_bf;
  logic signed [N-1:0] r_mem_r [8];
  logic signed [N-1:0] r_mem_i [8];

  logic                w_in_fire, w_out_fire, w_comp_done;
  logic [2:0]          w_lo, w_hi, w_rd;
  logic [1:0]          w_k;
  logic signed [Q+1:0] w_wr, w_wi;
  logic signed [N:0]   w_sr, w_si, w_dr, w_di;
  logic signed [P-1:0] w_pr, w_pi;
  logic signed [N-1:0] w_lr, w_li, w_hr, w_hi_i;

  assign w_in_fire   = bus.s_valid & bus.s_ready;
  assign w_out_fire  = bus.m_valid & bus.m_ready;
  assign w_comp_done = (r_state == ST_COMP) && (r_stage == 2'd2) && (r_bf == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: if (w_in_fire && r_in_cnt == 3'd7)   w_next = ST_COMP;
      ST_COMP: if (w_comp_done)                     w_next = ST_OUT;
      ST_OUT:  if (w_out_fire && r_out_cnt == 3'd7) w_next = ST_LOAD;
      default: w_next = ST_LOAD;
    endcase
  end

  // Output order is natural because the DIF result sits in bit-reversed slots.
  assign w_rd = {r_out_cnt[0], r_out_cnt[1], r_out_cnt[2]};

  always_comb begin
    bus.s_ready  = (r_state == ST_LOAD);
    bus.m_valid  = (r_state == ST_OUT);
    bus.busy     = (r_state != ST_LOAD);
    bus.m_last   = (r_state == ST_OUT) && (r_out_cnt == 3'd7);
    bus.m_data_r = '0;
    bus.m_data_i = '0;
    if (r_state == ST_OUT) begin
      bus.m_data_r = r_mem_r[w_rd];
      bus.m_data_i = r_mem_i[w_rd];
    end
  end

  always_comb begin
    w_lo = {1'b0, r_bf};
    w_hi = {1'b1, r_bf};
    w_k  = r_bf;
    case (r_stage)
      2'd0: begin w_lo = {1'b0, r_bf}; w_hi = {1'b1, r_bf}; w_k = r_bf; end
      2'd1: begin
        w_lo = {r_bf[1], 1'b0, r_bf[0]};
        w_hi = {r_bf[1], 1'b1, r_bf[0]};
        w_k  = {r_bf[0], 1'b0};
      end
      default: begin w_lo = {r_bf, 1'b0}; w_hi = {r_bf, 1'b1}; w_k = 2'd0; end
    endcase
  end

  // Conjugate twiddles exp(+j*2*pi*k/8).
  always_comb begin
    case (w_k)
      2'd0:    begin w_wr = (Q+2)'(ONE);  w_wi = '0;           end
      2'd1:    begin w_wr = (Q+2)'(C45);  w_wi = (Q+2)'(C45);  end
      2'd2:    begin w_wr = '0;           w_wi = (Q+2)'(ONE);  end
      default: begin w_wr = (Q+2)'(-C45); w_wi = (Q+2)'(C45);  end
    endcase
  end

  assign w_sr = (N+1)'(r_mem_r[w_lo]) + (N+1)'(r_mem_r[w_hi]);
  assign w_si = (N+1)'(r_mem_i[w_lo]) + (N+1)'(r_mem_i[w_hi]);
  assign w_dr = (N+1)'(r_mem_r[w_lo]) - (N+1)'(r_mem_r[w_hi]);
  assign w_di = (N+1)'(r_mem_i[w_lo]) - (N+1)'(r_mem_i[w_hi]);
  assign w_pr = P'(w_dr) * P'(w_wr) - P'(w_di) * P'(w_wi);
  assign w_pi = P'(w_dr) * P'(w_wi) + P'(w_di) * P'(w_wr);

`ifdef IFFT8_ROUND_EN
  localparam logic signed [P-1:0] SAT_HI = P'((1 << (N - 1)) - 1);
  localparam logic signed [P-1:0] SAT_LO = -P'(1 << (N - 1));

  function automatic logic signed [N-1:0] f_sat(input logic signed [P-1:0] v);
    if (v > SAT_HI)      f_sat = SAT_HI[N-1:0];
    else if (v < SAT_LO) f_sat = SAT_LO[N-1:0];
    else                 f_sat = v[N-1:0];
  endfunction

  logic signed [P-1:0] w_tr, w_ti;
  assign w_tr   = (w_pr + P'(1 << (Q - 1))) >>> Q;
  assign w_ti   = (w_pi + P'(1 << (Q - 1))) >>> Q;
  assign w_hr   = f_sat((w_tr + P'(1)) >>> 1);
  assign w_hi_i = f_sat((w_ti + P'(1)) >>> 1);
  assign w_lr   = f_sat((P'(w_sr) + P'(1)) >>> 1);
  assign w_li   = f_sat((P'(w_si) + P'(1)) >>> 1);
`else
  assign w_hr   = N'(w_pr >>> (Q + 1));
  assign w_hi_i = N'(w_pi >>> (Q + 1));
  assign w_lr   = N'(w_sr >>> 1);
  assign w_li   = N'(w_si >>> 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_stage   <= '0;
      r_bf      <= '0;
      for (int i = 0; i < 8; i++) begin
        r_mem_r[i] <= '0;
        r_mem_i[i] <= '0;
      end
    end else begin
      if (w_in_fire) begin
        r_mem_r[r_in_cnt] <= bus.s_data_r;
        r_mem_i[r_in_cnt] <= bus.s_data_i;
        r_in_cnt          <= r_in_cnt + 3'd1;
        if (r_in_cnt == 3'd7) begin
          r_stage <= '0;
          r_bf    <= '0;
        end
      end
      if (r_state == ST_COMP) begin
        r_mem_r[w_lo] <= w_lr;
        r_mem_i[w_lo] <= w_li;
        r_mem_r[w_hi] <= w_hr;
        r_mem_i[w_hi] <= w_hi_i;
        r_bf          <= r_bf + 2'd1;
        if (r_bf == 2'd3) r_stage <= (r_stage == 2'd2) ? 2'd0 : r_stage + 2'd1;
        if (w_comp_done)  r_out_cnt <= '0;
      end
      if (w_out_fire) r_out_cnt <= r_out_cnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_ifft8_seq.sv
// Directed bench for ifft8_seq: scoreboard of hand-derived expected samples, checked as the engine streams out.
module tb_ifft8_seq;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft8_seq_if #(.N(N)) bus();
  ifft8_seq #(.N(N), .Q(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int exp_r[$];
  int exp_i[$];
  int exp_t[$];
  int in_r[8];
  int in_i[8];
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
    n_cmp++;
    assert ((obs - expv <= tol) && (expv - obs <= tol)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, expv, tol);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected DUT event", tag);
  endtask

  task automatic push(input int r, input int i, input int t);
    exp_r.push_back(r);
    exp_i.push_back(i);
    exp_t.push_back(t);
  endtask

  task automatic clear_in();
    for (int k = 0; k < 8; k++) begin
      in_r[k] = 0;
      in_i[k] = 0;
    end
  endtask

  // Ends at the negedge after the 8th beat; junk keeps s_valid high to prove it is ignored.
  task automatic send_frame(input bit gaps, input bit junk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (gaps && (k % 2 == 1)) begin
        bus.s_valid  = 1'b0;
        bus.s_data_r = 16'sh7ABC;
        bus.s_data_i = 16'sh1234;
        @(negedge clk);
      end
      bus.s_valid  = 1'b1;
      bus.s_data_r = N'(in_r[k]);
      bus.s_data_i = N'(in_i[k]);
      begin
        int w = 0;
        while (!bus.s_ready && w < 100) begin
          @(negedge clk);
          w++;
        end
        if (w >= 100) timeout("s_ready_wait");
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.s_valid  = junk;
    bus.s_data_r = 16'sh4321;
    bus.s_data_i = -16'sh0777;
  endtask

  task automatic recv_frame(input bit bp);
    int low = 0;
    int got = 0;
    int cyc = 0;
    bit fire;
    while (!bus.m_valid && low < 100) begin
      chk("s_ready_compute", int'(bus.s_ready), 0);
      low++;
      @(negedge clk);
    end
    if (low >= 100) timeout("m_valid_wait");
    chk("latency", low + 1, 13);
    while (got < 8 && cyc < 200) begin
      bus.m_ready = bp ? (pat[cyc % 6] != 0) : 1'b1;
      #1;
      chk("m_valid", int'(bus.m_valid), 1);
      chk("s_ready_out", int'(bus.s_ready), 0);
      chk("busy_out", int'(bus.busy), 1);
      chk("m_last", int'(bus.m_last), (got == 7) ? 1 : 0);
      if (exp_r.size() > 0) begin
        chk_tol($sformatf("y%0d_r", got), int'(bus.m_data_r), exp_r[0], exp_t[0]);
        chk_tol($sformatf("y%0d_i", got), int'(bus.m_data_i), exp_i[0], exp_t[0]);
      end
      fire = bus.m_ready;
      @(posedge clk);
      if (fire) begin
        got++;
        if (exp_r.size() > 0) begin
          void'(exp_r.pop_front());
          void'(exp_i.pop_front());
          void'(exp_t.pop_front());
        end
      end
      cyc++;
      @(negedge clk);
    end
    if (got < 8) timeout("out_beats");
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    chk("s_ready_after", int'(bus.s_ready), 1);
    chk("m_valid_after", int'(bus.m_valid), 0);
    chk("busy_after", int'(bus.busy), 0);
    chk("sb_empty", exp_r.size(), 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data_r = '0;
    bus.s_data_i = '0;
    bus.m_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", int'(bus.s_ready), 1);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_last", int'(bus.m_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_m_data_r", int'(bus.m_data_r), 0);
    chk("rst_m_data_i", int'(bus.m_data_i), 0);
    rst = 1'b0;

    // Impulse at bin 0: every sample is 256/8.
    clear_in();
    in_r[0] = 256;
    for (int k = 0; k < 8; k++) push(32, 0, 0);
    send_frame(1'b0, 1'b0);
    recv_frame(1'b0);

    // Flat spectrum, with input gaps: energy lands on y0 only.
    clear_in();
    for (int k = 0; k < 8; k++) in_r[k] = 256;
    push(256, 0, 0);
    for (int k = 1; k < 8; k++) push(0, 0, 0);
    send_frame(1'b1, 1'b0);
    recv_frame(1'b0);

    // Single tone at bin 1: rotating phasor of amplitude 32.
    clear_in();
    in_r[1] = 256;
    push(32, 0, 0);   push(22, 22, 1);  push(0, 32, 0);   push(-22, 22, 1);
    push(-32, 0, 0);  push(-22, -22, 1); push(0, -32, 0); push(22, -22, 1);
    send_frame(1'b0, 1'b0);
    recv_frame(1'b0);

    // Same tone under output backpressure, with s_valid junk held high while busy.
    push(32, 0, 0);   push(22, 22, 1);  push(0, 32, 0);   push(-22, 22, 1);
    push(-32, 0, 0);  push(-22, -22, 1); push(0, -32, 0); push(22, -22, 1);
    send_frame(1'b0, 1'b1);
    recv_frame(1'b1);

    // Reset in the 5th compute cycle, then a clean impulse frame.
    clear_in();
    in_r[0] = 256;
    send_frame(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", int'(bus.m_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_s_ready", int'(bus.s_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) push(32, 0, 0);
    send_frame(1'b0, 1'b0);
    recv_frame(1'b0);

    // Full-scale flat spectrum: y0 reaches +max with no wrap.
    clear_in();
    for (int k = 0; k < 8; k++) in_r[k] = 32767;
    push(32767, 0, 0);
    for (int k = 1; k < 8; k++) push(0, 0, 0);
    send_frame(1'b0, 1'b0);
    recv_frame(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
